reorder_buffer: RTL and testbench

- In-order retirement stage of the out-of-order core; sits directly upstream of the commit tracker and the store buffer.
- Allocates one entry per dispatched instruction and records out-of-order writeback completion and store address/data.
- Retires at most one instruction per cycle in program order on registered commit_* / st_* outputs, which the commit tracker samples.
- Squashes younger entries on a branch-mispredict flush.

---
 rtl/reorder_buffer_if.sv | 56 +++++
 rtl/reorder_buffer.sv | 183 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, flush and retirement signals of the reorder buffer.
// The master modport is the core side; the slave modport is the ROB.
interface reorder_buffer_if #(
  parameter int IDX_W = 4
);
  logic             dis_valid;
  logic             dis_ready;
  logic [31:0]      dis_pc;
  logic [31:0]      dis_inst;
  logic [5:0]       dis_Ard;
  logic             dis_is_store;
  logic [IDX_W-1:0] dis_rob_idx;

  logic             wb_valid;
  logic [IDX_W-1:0] wb_rob_idx;
  logic [31:0]      wb_data;

  logic             st_wb_valid;
  logic [IDX_W-1:0] st_wb_rob_idx;
  logic [31:0]      st_wb_addr;
  logic [31:0]      st_wb_data;
  logic             st_ready;

  logic             flush_valid;
  logic [IDX_W-1:0] flush_rob_idx;

  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_inst;
  logic [5:0]       commit_Ard;
  logic [31:0]      commit_data;
  logic             st_commit;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             rob_empty;

  modport master (
    output dis_valid, dis_pc, dis_inst, dis_Ard, dis_is_store,
    output wb_valid, wb_rob_idx, wb_data,
    output st_wb_valid, st_wb_rob_idx, st_wb_addr, st_wb_data, st_ready,
    output flush_valid, flush_rob_idx,
    input  dis_ready, dis_rob_idx,
    input  commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
    input  st_commit, st_addr, st_data, rob_empty
  );

  modport slave (
    input  dis_valid, dis_pc, dis_inst, dis_Ard, dis_is_store,
    input  wb_valid, wb_rob_idx, wb_data,
    input  st_wb_valid, st_wb_rob_idx, st_wb_addr, st_wb_data, st_ready,
    input  flush_valid, flush_rob_idx,
    output dis_ready, dis_rob_idx,
    output commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
    output st_commit, st_addr, st_data, rob_empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement ROB: allocates at dispatch, completes out of order, retires one per cycle.
// Define ROB_PERF_CNT_EN to build the 64-bit commit/stall performance counters.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  reorder_buffer_if.slave     bus,
  output logic [63:0]         perf_commit_cnt,
  output logic [63:0]         perf_stall_cnt
);

  localparam logic [IDX_W:0] DEPTH_P = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_P   = (IDX_W+1)'(1);

  // Pointers carry a wrap bit so that full and empty are distinguishable.
  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W:0]   count;
  logic [IDX_W:0]   head_nx;
  logic [IDX_W:0]   tail_nx;
  logic [IDX_W:0]   count_nx;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] valid_nx;
  logic [DEPTH-1:0] done_nx;
  logic [DEPTH-1:0] kill;

  logic             ent_store [DEPTH];
  logic [31:0]      ent_pc    [DEPTH];
  logic [31:0]      ent_inst  [DEPTH];
  logic [5:0]       ent_ard   [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [31:0]      ent_addr  [DEPTH];
  logic [31:0]      ent_sdata [DEPTH];

  logic             head_valid;
  logic             head_done;
  logic             head_store;
  logic             retire;
  logic             dis_fire;
  logic             wb_ok;
  logic             st_wb_ok;
  logic [IDX_W-1:0] flush_off;
  logic             flush_ok;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  assign head_valid = ent_valid[head_idx];
  assign head_done  = ent_done[head_idx];
  assign head_store = ent_store[head_idx];

  // A store may only leave when the store buffer can take it, which blocks everything behind it.
  assign retire = head_valid && head_done && (!head_store || bus.st_ready);

  assign bus.dis_ready   = (count < DEPTH_P) && !bus.flush_valid;
  assign bus.dis_rob_idx = tail_idx;
  assign bus.rob_empty   = (count == '0);
  assign dis_fire        = bus.dis_valid && bus.dis_ready;

  assign wb_ok    = bus.wb_valid && ent_valid[bus.wb_rob_idx];
  assign st_wb_ok = bus.st_wb_valid && ent_valid[bus.st_wb_rob_idx];

  // The flush target is accepted only if its age offset from head lies inside the occupied window.
  assign flush_off = bus.flush_rob_idx - head_idx;
  assign flush_ok  = bus.flush_valid && ({1'b0, flush_off} < count);

  for (genvar i = 0; i < DEPTH; i++) begin : g_kill
    logic [IDX_W-1:0] off;
    assign off     = IDX_W'(i) - head_idx;
    assign kill[i] = flush_ok && (off > flush_off) && ({1'b0, off} < count);
  end

  always_comb begin
    head_nx = head + (IDX_W+1)'(retire);
    if (flush_ok) begin
      tail_nx = head + {1'b0, flush_off} + ONE_P;
    end else begin
      tail_nx = tail + (IDX_W+1)'(dis_fire);
    end
    count_nx = tail_nx - head_nx;
  end

  // Flush and dispatch are mutually exclusive, and a full ROB never dispatches onto the retiring head.
  always_comb begin
    valid_nx = ent_valid;
    done_nx  = ent_done;
    if (wb_ok) begin
      done_nx[bus.wb_rob_idx] = 1'b1;
    end
    if (st_wb_ok) begin
      done_nx[bus.st_wb_rob_idx] = 1'b1;
    end
    if (retire) begin
      valid_nx[head_idx] = 1'b0;
      done_nx[head_idx]  = 1'b0;
    end
    valid_nx = valid_nx & ~kill;
    done_nx  = done_nx & ~kill;
    if (dis_fire) begin
      valid_nx[tail_idx] = 1'b1;
      done_nx[tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      head      <= head_nx;
      tail      <= tail_nx;
      count     <= count_nx;
      ent_valid <= valid_nx;
      ent_done  <= done_nx;
    end
  end

  // Payload needs no reset: it is only observed once valid and done bits say so.
  always_ff @(posedge clk) begin
    if (dis_fire) begin
      ent_pc[tail_idx]    <= bus.dis_pc;
      ent_inst[tail_idx]  <= bus.dis_inst;
      ent_ard[tail_idx]   <= bus.dis_Ard;
      ent_store[tail_idx] <= bus.dis_is_store;
    end
    if (wb_ok) begin
      ent_data[bus.wb_rob_idx] <= bus.wb_data;
    end
    if (st_wb_ok) begin
      ent_addr[bus.st_wb_rob_idx]  <= bus.st_wb_addr;
      ent_sdata[bus.st_wb_rob_idx] <= bus.st_wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.commit_valid <= 1'b0;
      bus.commit_pc    <= '0;
      bus.commit_inst  <= '0;
      bus.commit_Ard   <= '0;
      bus.commit_data  <= '0;
      bus.st_commit    <= 1'b0;
      bus.st_addr      <= '0;
      bus.st_data      <= '0;
    end else begin
      bus.commit_valid <= retire;
      if (retire) begin
        bus.commit_pc   <= ent_pc[head_idx];
        bus.commit_inst <= ent_inst[head_idx];
        bus.st_commit   <= head_store;
        bus.commit_Ard  <= head_store ? 6'd0  : ent_ard[head_idx];
        bus.commit_data <= head_store ? 32'd0 : ent_data[head_idx];
        bus.st_addr     <= head_store ? ent_addr[head_idx]  : 32'd0;
        bus.st_data     <= head_store ? ent_sdata[head_idx] : 32'd0;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commit_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      perf_commit_cnt <= perf_commit_cnt + 64'(retire);
      perf_stall_cnt  <= perf_stall_cnt + 64'(head_valid && !retire);
    end
  end
`else
  assign perf_commit_cnt = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic        clk;
  logic        rst;
  logic [63:0] perf_commit_cnt;
  logic [63:0] perf_stall_cnt;

  reorder_buffer_if #(.IDX_W(IDX_W)) bus();

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .perf_commit_cnt (perf_commit_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  ard;
    logic        is_store;
    logic        done;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] sdata;
  } ent_t;

  // Model: queue in program order, oldest at index 0, occupying slots m_head, m_head+1, ...
  ent_t        mq[$];
  int          m_head;
  longint      m_commits;
  longint      m_stalls;
  logic        exp_cv;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [5:0]  exp_ard;
  logic [31:0] exp_data;
  logic        exp_stc;
  logic [31:0] exp_saddr;
  logic [31:0] exp_sdata;

  task automatic set_idle();
    bus.dis_valid     = 1'b0;
    bus.dis_pc        = '0;
    bus.dis_inst      = '0;
    bus.dis_Ard       = '0;
    bus.dis_is_store  = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rob_idx    = '0;
    bus.wb_data       = '0;
    bus.st_wb_valid   = 1'b0;
    bus.st_wb_rob_idx = '0;
    bus.st_wb_addr    = '0;
    bus.st_wb_data    = '0;
    bus.st_ready      = 1'b1;
    bus.flush_valid   = 1'b0;
    bus.flush_rob_idx = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_head    = 0;
    m_commits = 0;
    m_stalls  = 0;
    exp_cv    = 0;
    exp_pc    = '0;
    exp_inst  = '0;
    exp_ard   = '0;
    exp_data  = '0;
    exp_stc   = 0;
    exp_saddr = '0;
    exp_sdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    model_clear();
    #2;
    rst = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [31:0] pc, input logic [5:0] ard, input logic st);
    bus.dis_valid    = 1'b1;
    bus.dis_pc       = pc;
    bus.dis_inst     = $urandom;
    bus.dis_Ard      = ard;
    bus.dis_is_store = st;
  endtask

  // Advance the model by one clock using the driven inputs, then step the DUT past the edge.
  task automatic tick();
    ent_t e;
    int   sz;
    int   pos;
    bit   ret;
    bit   rdy;
    sz  = mq.size();
    ret = (sz > 0) && mq[0].done && (!mq[0].is_store || bus.st_ready);
    rdy = (sz < DEPTH) && !bus.flush_valid;
    if (ret) begin
      m_commits++;
      e         = mq[0];
      exp_cv    = 1;
      exp_pc    = e.pc;
      exp_inst  = e.inst;
      exp_stc   = e.is_store;
      exp_ard   = e.is_store ? 6'd0 : e.ard;
      exp_data  = e.is_store ? 32'd0 : e.data;
      exp_saddr = e.is_store ? e.addr : 32'd0;
      exp_sdata = e.is_store ? e.sdata : 32'd0;
    end else begin
      exp_cv = 0;
      if (sz > 0) m_stalls++;
    end
    if (bus.wb_valid) begin
      pos = (int'(bus.wb_rob_idx) - m_head + DEPTH) % DEPTH;
      if (pos < sz) begin
        e = mq[pos]; e.done = 1; e.data = bus.wb_data; mq[pos] = e;
      end
    end
    if (bus.st_wb_valid) begin
      pos = (int'(bus.st_wb_rob_idx) - m_head + DEPTH) % DEPTH;
      if (pos < sz) begin
        e = mq[pos]; e.done = 1; e.addr = bus.st_wb_addr; e.sdata = bus.st_wb_data; mq[pos] = e;
      end
    end
    if (bus.flush_valid) begin
      pos = (int'(bus.flush_rob_idx) - m_head + DEPTH) % DEPTH;
      if (pos < sz) begin
        while (mq.size() > pos + 1) mq.delete(mq.size() - 1);
      end
    end
    if (bus.dis_valid && rdy) begin
      e.pc = bus.dis_pc; e.inst = bus.dis_inst; e.ard = bus.dis_Ard;
      e.is_store = bus.dis_is_store; e.done = 0; e.data = '0; e.addr = '0; e.sdata = '0;
      mq.push_back(e);
    end
    if (ret) begin
      mq.delete(0);
      m_head = (m_head + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    model_clear();
    #1;
    checks++; if (bus.dis_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dis_ready got %b want 1", bus.dis_ready); end
    checks++; if (bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rob_empty got %b want 1", bus.rob_empty); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_valid got %b want 0", bus.commit_valid); end
    checks++; if (bus.dis_rob_idx !== 4'd0) begin errors++; $display("[TB] FAIL reset_dis_rob_idx got %0d want 0", bus.dis_rob_idx); end
    checks++; if (bus.commit_pc !== 32'd0 || bus.st_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_outputs got pc %h st_addr %h want 0", bus.commit_pc, bus.st_addr); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_in_order();
    logic [31:0] want_pc [3];
    int          wb_order [3];
    want_pc  = '{32'h2000, 32'h2004, 32'h2008};
    wb_order = '{2, 0, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(32'h2000 + 32'(4 * i), 6'(5 + i), 1'b0);
      #1;
      checks++; if (bus.dis_rob_idx !== 4'(i)) begin errors++; $display("[TB] FAIL order_alloc_idx got %0d want %0d", bus.dis_rob_idx, i); end
      tick();
    end
    set_idle();
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid   = 1'b1;
      bus.wb_rob_idx = 4'(wb_order[i]);
      bus.wb_data    = 32'h100 + 32'(wb_order[i]);
      tick();
      if (i == 1) begin
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_no_bypass got %b want 0", bus.commit_valid); end
      end
    end
    set_idle();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_pc !== want_pc[i]) begin errors++; $display("[TB] FAIL order_commit_%0d got v=%b pc=%h want v=1 pc=%h", i, bus.commit_valid, bus.commit_pc, want_pc[i]); end
      checks++; if (bus.commit_data !== 32'h100 + 32'(i) || bus.commit_Ard !== 6'(5 + i)) begin errors++; $display("[TB] FAIL order_commit_data_%0d got %h/%0d want %h/%0d", i, bus.commit_data, bus.commit_Ard, 32'h100 + 32'(i), 5 + i); end
    end
    tick();
    checks++; if (bus.commit_valid !== 1'b0 || bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL order_drained got v=%b empty=%b want v=0 empty=1", bus.commit_valid, bus.rob_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_dispatch(32'h3000 + 32'(4 * i), 6'(i + 1), 1'b0);
      tick();
    end
    drive_dispatch(32'h3FFC, 6'd1, 1'b0);
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 4'd0;
    bus.wb_data    = 32'hABCD;
    #1;
    checks++; if (bus.dis_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_dis_ready got %b want 0", bus.dis_ready); end
    tick();
    set_idle();
    #1;
    checks++; if (bus.dis_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_dis_ready got %b want 0", bus.dis_ready); end
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_pc !== 32'h3000) begin errors++; $display("[TB] FAIL full_retire0 got v=%b pc=%h want v=1 pc=00003000", bus.commit_valid, bus.commit_pc); end
    checks++; if (bus.dis_ready !== 1'b1 || bus.dis_rob_idx !== 4'd0) begin errors++; $display("[TB] FAIL full_wrap_alloc got ready=%b idx=%0d want ready=1 idx=0", bus.dis_ready, bus.dis_rob_idx); end
    drive_dispatch(32'h4000, 6'd3, 1'b0);
    tick();
    set_idle();
    #1;
    checks++; if (bus.dis_ready !== 1'b0 || bus.dis_rob_idx !== 4'd1) begin errors++; $display("[TB] FAIL full_after_wrap got ready=%b idx=%0d want ready=0 idx=1", bus.dis_ready, bus.dis_rob_idx); end
  endtask

  task automatic test_store_stall();
    do_reset();
    drive_dispatch(32'h200C, 6'd9, 1'b1);
    tick();
    set_idle();
    bus.st_ready      = 1'b0;
    bus.st_wb_valid   = 1'b1;
    bus.st_wb_rob_idx = 4'd0;
    bus.st_wb_addr    = 32'h8000_0004;
    bus.st_wb_data    = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.st_wb_valid = 1'b0;
      checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_blocked_%0d got %b want 0", i, bus.commit_valid); end
    end
    bus.st_ready = 1'b1;
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.st_commit !== 1'b1 || bus.commit_pc !== 32'h200C) begin errors++; $display("[TB] FAIL store_commit got v=%b st=%b pc=%h want 1 1 0000200c", bus.commit_valid, bus.st_commit, bus.commit_pc); end
    checks++; if (bus.st_addr !== 32'h8000_0004 || bus.st_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL store_payload got %h/%h want 80000004/00001234", bus.st_addr, bus.st_data); end
    checks++; if (bus.commit_Ard !== 6'd0 || bus.commit_data !== 32'd0) begin errors++; $display("[TB] FAIL store_zero_fields got ard=%0d data=%h want 0/0", bus.commit_Ard, bus.commit_data); end
  endtask

  task automatic test_flush();
    logic [31:0] want [4];
    logic [31:0] got[$];
    want = '{32'h5000, 32'h5004, 32'h5008, 32'h7000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_dispatch(32'h5000 + 32'(4 * i), 6'(10 + i), 1'b0);
      tick();
    end
    drive_dispatch(32'h6000, 6'd1, 1'b0);
    bus.flush_valid   = 1'b1;
    bus.flush_rob_idx = 4'd2;
    #1;
    checks++; if (bus.dis_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_dis_ready got %b want 0", bus.dis_ready); end
    tick();
    set_idle();
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 4'd4;
    bus.wb_data    = 32'hDEAD;
    #1;
    checks++; if (bus.dis_rob_idx !== 4'd3) begin errors++; $display("[TB] FAIL flush_tail got %0d want 3", bus.dis_rob_idx); end
    tick();
    set_idle();
    drive_dispatch(32'h7000, 6'd20, 1'b0);
    #1;
    checks++; if (bus.dis_rob_idx !== 4'd3 || bus.dis_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_alloc got idx=%0d ready=%b want 3 1", bus.dis_rob_idx, bus.dis_ready); end
    tick();
    set_idle();
    for (int i = 0; i < 7; i++) begin
      bus.wb_valid   = (i < 4);
      bus.wb_rob_idx = 4'(i);
      bus.wb_data    = 32'(i);
      tick();
      if (bus.commit_valid === 1'b1) got.push_back(bus.commit_pc);
    end
    set_idle();
    checks++; if (got.size() != 4) begin errors++; $display("[TB] FAIL flush_commit_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin errors++; $display("[TB] FAIL flush_commit_pc_%0d got %h want %h", i, got[i], want[i]); end
    end
    checks++; if (bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got %b want 1", bus.rob_empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_dispatch(32'h8000 + 32'(4 * i), 6'(i + 1), 1'b0);
      tick();
    end
    set_idle();
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 4'd0;
    tick();
    set_idle();
    tick();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_commit got %b want 1", bus.commit_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_commit_valid got %b want 0", bus.commit_valid); end
    checks++; if (bus.rob_empty !== 1'b1 || bus.dis_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_status got empty=%b ready=%b want 1 1", bus.rob_empty, bus.dis_ready); end
    checks++; if (bus.dis_rob_idx !== 4'd0) begin errors++; $display("[TB] FAIL areset_tail got %0d want 0", bus.dis_rob_idx); end
    model_clear();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_perf();
    logic [63:0] want_c;
    logic [63:0] want_s;
`ifdef ROB_PERF_CNT_EN
    want_c = 64'd3;
    want_s = 64'd4;
`else
    want_c = 64'd0;
    want_s = 64'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(32'h9000 + 32'(4 * i), 6'(i + 1), 1'b0);
      tick();
    end
    set_idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid   = 1'b1;
      bus.wb_rob_idx = 4'(i);
      bus.wb_data    = 32'(i);
      tick();
    end
    set_idle();
    tick();
    tick();
    checks++; if (perf_commit_cnt !== want_c) begin errors++; $display("[TB] FAIL perf_commit got %0d want %0d", perf_commit_cnt, want_c); end
    checks++; if (perf_stall_cnt !== want_s) begin errors++; $display("[TB] FAIL perf_stall got %0d want %0d", perf_stall_cnt, want_s); end
  endtask

  task automatic test_random();
    int k;
    int k2;
    int wb_idx;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_idle();
      wb_idx = -1;
      if ($urandom_range(0, 99) < 55)
        drive_dispatch($urandom, 6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0));
      if (mq.size() > 0 && $urandom_range(0, 99) < 60) begin
        k = $urandom_range(0, mq.size() - 1);
        if (!mq[k].is_store) begin
          wb_idx         = (m_head + k) % DEPTH;
          bus.wb_valid   = 1'b1;
          bus.wb_rob_idx = 4'(wb_idx);
          bus.wb_data    = $urandom;
        end
      end
      if (mq.size() > 0 && $urandom_range(0, 99) < 50) begin
        k2 = $urandom_range(0, mq.size() - 1);
        if (mq[k2].is_store && ((m_head + k2) % DEPTH) != wb_idx) begin
          bus.st_wb_valid   = 1'b1;
          bus.st_wb_rob_idx = 4'((m_head + k2) % DEPTH);
          bus.st_wb_addr    = $urandom;
          bus.st_wb_data    = $urandom;
        end
      end
      bus.st_ready = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 4) begin
        bus.flush_valid   = 1'b1;
        bus.flush_rob_idx = 4'($urandom_range(0, DEPTH - 1));
      end
      #1;
      checks++; if (bus.dis_ready !== ((mq.size() < DEPTH) && !bus.flush_valid)) begin errors++; $display("[TB] FAIL rnd_dis_ready cyc %0d got %b want %b", cyc, bus.dis_ready, (mq.size() < DEPTH) && !bus.flush_valid); end
      checks++; if (bus.dis_rob_idx !== 4'((m_head + mq.size()) % DEPTH)) begin errors++; $display("[TB] FAIL rnd_dis_rob_idx cyc %0d got %0d want %0d", cyc, bus.dis_rob_idx, (m_head + mq.size()) % DEPTH); end
      checks++; if (bus.rob_empty !== (mq.size() == 0)) begin errors++; $display("[TB] FAIL rnd_rob_empty cyc %0d got %b want %b", cyc, bus.rob_empty, mq.size() == 0); end
      tick();
      checks++; if (bus.commit_valid !== exp_cv) begin errors++; $display("[TB] FAIL rnd_commit_valid cyc %0d got %b want %b", cyc, bus.commit_valid, exp_cv); end
      checks++; if (bus.commit_pc !== exp_pc || bus.commit_inst !== exp_inst) begin errors++; $display("[TB] FAIL rnd_commit_pc_inst cyc %0d got %h/%h want %h/%h", cyc, bus.commit_pc, bus.commit_inst, exp_pc, exp_inst); end
      checks++; if (bus.commit_Ard !== exp_ard || bus.commit_data !== exp_data) begin errors++; $display("[TB] FAIL rnd_commit_ard_data cyc %0d got %0d/%h want %0d/%h", cyc, bus.commit_Ard, bus.commit_data, exp_ard, exp_data); end
      checks++; if (bus.st_commit !== exp_stc || bus.st_addr !== exp_saddr || bus.st_data !== exp_sdata) begin errors++; $display("[TB] FAIL rnd_store cyc %0d got %b/%h/%h want %b/%h/%h", cyc, bus.st_commit, bus.st_addr, bus.st_data, exp_stc, exp_saddr, exp_sdata); end
    end
    set_idle();
`ifdef ROB_PERF_CNT_EN
    checks++; if (perf_commit_cnt !== 64'(m_commits) || perf_stall_cnt !== 64'(m_stalls)) begin errors++; $display("[TB] FAIL rnd_perf got %0d/%0d want %0d/%0d", perf_commit_cnt, perf_stall_cnt, m_commits, m_stalls); end
`else
    checks++; if (perf_commit_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin errors++; $display("[TB] FAIL rnd_perf got %0d/%0d want 0/0", perf_commit_cnt, perf_stall_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_store_stall();
    test_flush();
    test_async_reset();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
